maze_player_mover: RTL and testbench

Player movement controller feeding the LT24 maze renderer: turns the four direction buttons into validated one-cell moves on the WIDTH×HEIGHT maze grid. Reads candidate cells from the maze memory over its own read port and commits a move only into open cells. Drives the `player_x`/`player_y` coordinates the renderer compares against the tile under the cursor. Flags arrival at the exit cell.

---
 rtl/maze_player_mover.sv | 138 +++++++++++++
 tb/tb_maze_player_mover.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_player_mover.sv
// Player movement controller: turns direction buttons into wall-checked one-cell moves on the maze grid.
// Optional hold-to-repeat behaviour is enabled by defining PLAYER_AUTOREPEAT_EN.
module maze_player_mover #(
  parameter int unsigned WIDTH        = 30,
  parameter int unsigned HEIGHT       = 40,
  parameter int unsigned START_X      = 1,
  parameter int unsigned START_Y      = 1,
  parameter int unsigned REPEAT_TICKS = 12500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  player_direction,
  output logic [10:0] maze_address,
  output logic        maze_read,
  input  logic        maze_data,
  output logic [7:0]  player_x,
  output logic [7:0]  player_y,
  output logic [15:0] move_count,
  output logic        at_exit,
  output logic        busy
);

  localparam int unsigned AW = 11;
  localparam int unsigned CW = 8;
  localparam int unsigned HW = 24;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CHECK} state_t;

  state_t          state;
  logic [3:0]      s1, s2, prev;
  logic [CW-1:0]   tx, ty;
  logic [CW-1:0]   tgt_x_c, tgt_y_c;
  logic            off_grid_c;
  logic            dir_valid_c;
  logic            press_event_c;
  logic            request_c;
  logic            at_exit_cell_c;

  assign dir_valid_c   = $onehot(s2);
  assign press_event_c = dir_valid_c && (s2 != prev);

`ifdef PLAYER_AUTOREPEAT_EN
  logic [HW-1:0] hold_cnt;
  logic          repeat_tick_c;

  assign repeat_tick_c = dir_valid_c && (s2 == prev) && (state == IDLE) &&
                         (hold_cnt == HW'(REPEAT_TICKS - 1));
  assign request_c     = press_event_c || repeat_tick_c;

  // Hold timer: restarts on any change of the synchronized buttons, only runs while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (s2 != prev) begin
      hold_cnt <= '0;
    end else if (dir_valid_c && (state == IDLE)) begin
      hold_cnt <= repeat_tick_c ? '0 : hold_cnt + HW'(1);
    end
  end
`else
  logic unused_repeat_ticks;
  assign unused_repeat_ticks = ^REPEAT_TICKS;
  assign request_c           = press_event_c;
`endif

  // Candidate cell for the current button, with off-grid moves flagged instead of wrapped.
  always_comb begin
    tgt_x_c    = player_x;
    tgt_y_c    = player_y;
    off_grid_c = 1'b0;
    case (s2)
      4'b0001: if (player_y == '0) off_grid_c = 1'b1;
               else tgt_y_c = player_y - CW'(1);
      4'b0010: if (player_y == CW'(HEIGHT - 1)) off_grid_c = 1'b1;
               else tgt_y_c = player_y + CW'(1);
      4'b0100: if (player_x == '0) off_grid_c = 1'b1;
               else tgt_x_c = player_x - CW'(1);
      4'b1000: if (player_x == CW'(WIDTH - 1)) off_grid_c = 1'b1;
               else tgt_x_c = player_x + CW'(1);
      default: off_grid_c = 1'b1;
    endcase
  end

  assign at_exit_cell_c = (tx == CW'(WIDTH - 2)) && (ty == CW'(HEIGHT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s1           <= '0;
      s2           <= '0;
      prev         <= '0;
      tx           <= CW'(START_X);
      ty           <= CW'(START_Y);
      maze_address <= '0;
      maze_read    <= 1'b0;
      player_x     <= CW'(START_X);
      player_y     <= CW'(START_Y);
      move_count   <= '0;
      at_exit      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      s1        <= player_direction;
      s2        <= s1;
      prev      <= s2;
      maze_read <= 1'b0;
      case (state)
        IDLE: begin
          if (request_c && !at_exit && !off_grid_c) begin
            tx           <= tgt_x_c;
            ty           <= tgt_y_c;
            maze_address <= AW'(tgt_x_c) + AW'(WIDTH) * AW'(tgt_y_c);
            maze_read    <= 1'b1;
            busy         <= 1'b1;
            state        <= REQ;
          end
        end
        REQ:  state <= WAIT;
        WAIT: state <= CHECK;
        CHECK: begin
          // Commit only into open cells; a wall leaves everything untouched.
          if (maze_data) begin
            player_x <= tx;
            player_y <= ty;
            if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
            if (at_exit_cell_c) at_exit <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maze_player_mover.sv
// Self-checking bench for maze_player_mover: 2-cycle-latency maze memory model plus read-address scoreboard.
module tb_maze_player_mover;

  localparam int unsigned W = 30;
  localparam int unsigned H = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  player_direction = 4'b0000;
  logic [10:0] maze_address;
  logic        maze_read;
  logic        maze_data = 1'b0;
  logic [7:0]  player_x;
  logic [7:0]  player_y;
  logic [15:0] move_count;
  logic        at_exit;
  logic        busy;

  logic        mem [0:2047];
  logic        d1 = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          reads  = 0;
  int          exp_q [$];

  maze_player_mover #(
    .WIDTH(W), .HEIGHT(H), .START_X(1), .START_Y(1), .REPEAT_TICKS(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .player_direction(player_direction),
    .maze_address(maze_address),
    .maze_read(maze_read),
    .maze_data(maze_data),
    .player_x(player_x),
    .player_y(player_y),
    .move_count(move_count),
    .at_exit(at_exit),
    .busy(busy)
  );

  always #10 clock = ~clock;

  // Maze memory: data appears two cycles after the address is presented.
  always @(posedge clock) begin
    d1        <= mem[maze_address];
    maze_data <= d1;
  end

  // Scoreboard: every read strobe must match the next expected address.
  always @(negedge clock) begin
    if (!reset && maze_read) begin
      int e;
      reads  = reads + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_read: address %0d, none expected", maze_address);
      end else begin
        e = exp_q.pop_front();
        if (maze_address !== 11'(e)) begin
          errors = errors + 1;
          $display("FAIL read_address: got %0d expected %0d", maze_address, e);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    player_direction = 4'b0000;
    exp_q.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic press(input logic [3:0] dir, input bit exp_read, input int addr);
    @(negedge clock);
    player_direction = dir;
    if (exp_read) exp_q.push_back(addr);
    repeat (8) @(posedge clock);
    @(negedge clock);
    player_direction = 4'b0000;
    repeat (4) @(posedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    checks = checks + 1;
    if ({player_x, player_y} !== {8'd1, 8'd1}) begin
      errors = errors + 1;
      $display("FAIL reset_pos: got (%0d,%0d) expected (1,1)", player_x, player_y);
    end
    checks = checks + 1;
    if ({maze_address, maze_read, busy, at_exit} !== 14'd0 || move_count !== 16'd0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: addr %0d read %0b busy %0b exit %0b count %0d expected all 0",
               maze_address, maze_read, busy, at_exit, move_count);
    end
  endtask

  task automatic test_basic_right();
    int r0;
    do_reset();
    r0 = reads;
    @(negedge clock);
    player_direction = 4'b1000;
    exp_q.push_back(32);
    repeat (5) @(posedge clock);
    #1;
    checks = checks + 1;
    if (player_x !== 8'd1) begin
      errors = errors + 1;
      $display("FAIL latency_early: player_x %0d after 5 edges, expected 1", player_x);
    end
    @(posedge clock);
    #1;
    checks = checks + 1;
    if (player_x !== 8'd2) begin
      errors = errors + 1;
      $display("FAIL latency_6: player_x %0d after 6 edges, expected 2", player_x);
    end
    repeat (4) @(posedge clock);
    @(negedge clock);
    player_direction = 4'b0000;
    repeat (4) @(posedge clock);
    #1;
    checks = checks + 1;
    if (reads - r0 !== 1 || move_count !== 16'd1) begin
      errors = errors + 1;
      $display("FAIL basic_right: reads %0d count %0d, expected 1 and 1", reads - r0, move_count);
    end
  endtask

  task automatic test_wall();
    int r0;
    do_reset();
    mem[1] = 1'b0;
    r0 = reads;
    press(4'b0001, 1'b1, 1);
    #1;
    checks = checks + 1;
    if ({player_x, player_y} !== {8'd1, 8'd1} || move_count !== 16'd0 || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL wall: pos (%0d,%0d) count %0d busy %0b, expected (1,1) 0 0",
               player_x, player_y, move_count, busy);
    end
    checks = checks + 1;
    if (reads - r0 !== 1) begin
      errors = errors + 1;
      $display("FAIL wall_read: reads %0d expected 1", reads - r0);
    end
    mem[1] = 1'b1;
  endtask

  task automatic test_edge();
    int r0;
    do_reset();
    press(4'b0100, 1'b1, 0 + W * 1);
    for (int y = 2; y <= 5; y++) press(4'b0010, 1'b1, 0 + W * y);
    r0 = reads;
    press(4'b0100, 1'b0, 0);
    press(4'b0101, 1'b0, 0);
    press(4'b1100, 1'b0, 0);
    #1;
    checks = checks + 1;
    if ({player_x, player_y} !== {8'd0, 8'd5} || move_count !== 16'd5) begin
      errors = errors + 1;
      $display("FAIL edge_pos: pos (%0d,%0d) count %0d, expected (0,5) 5",
               player_x, player_y, move_count);
    end
    checks = checks + 1;
    if (reads - r0 !== 0 || exp_q.size() !== 0) begin
      errors = errors + 1;
      $display("FAIL edge_reads: extra reads %0d pending %0d, expected 0 0", reads - r0, exp_q.size());
    end
  endtask

  task automatic test_exit();
    int r0;
    do_reset();
    for (int x = 2; x <= 27; x++) press(4'b1000, 1'b1, x + W * 1);
    for (int y = 2; y <= 39; y++) press(4'b0010, 1'b1, 27 + W * y);
    #1;
    checks = checks + 1;
    if ({player_x, player_y} !== {8'd27, 8'd39} || at_exit !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL pre_exit: pos (%0d,%0d) exit %0b, expected (27,39) 0", player_x, player_y, at_exit);
    end
    press(4'b1000, 1'b1, 28 + W * 39);
    #1;
    checks = checks + 1;
    if ({player_x, player_y} !== {8'd28, 8'd39} || at_exit !== 1'b1 || move_count !== 16'd65) begin
      errors = errors + 1;
      $display("FAIL exit: pos (%0d,%0d) exit %0b count %0d, expected (28,39) 1 65",
               player_x, player_y, at_exit, move_count);
    end
    r0 = reads;
    press(4'b0100, 1'b0, 0);
    press(4'b0001, 1'b0, 0);
    #1;
    checks = checks + 1;
    if (reads - r0 !== 0 || at_exit !== 1'b1 || player_x !== 8'd28 || exp_q.size() !== 0) begin
      errors = errors + 1;
      $display("FAIL exit_sticky: reads %0d exit %0b x %0d pending %0d, expected 0 1 28 0",
               reads - r0, at_exit, player_x, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clock);
    player_direction = 4'b1000;
    exp_q.push_back(32);
    repeat (4) @(posedge clock);
    #1;
    checks = checks + 1;
    if (busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL mid_busy: busy %0b in WAIT, expected 1", busy);
    end
    reset = 1'b1;
    #1;
    checks = checks + 1;
    if ({player_x, player_y} !== {8'd1, 8'd1} || busy !== 1'b0 || maze_address !== 11'd0) begin
      errors = errors + 1;
      $display("FAIL mid_reset: pos (%0d,%0d) busy %0b addr %0d, expected (1,1) 0 0",
               player_x, player_y, busy, maze_address);
    end
    player_direction = 4'b0000;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    checks = checks + 1;
    if (player_x !== 8'd1 || move_count !== 16'd0) begin
      errors = errors + 1;
      $display("FAIL mid_no_commit: x %0d count %0d, expected 1 0", player_x, move_count);
    end
  endtask

  task automatic test_hold();
    int exp_moves;
    do_reset();
    @(negedge clock);
    player_direction = 4'b0010;
`ifdef PLAYER_AUTOREPEAT_EN
    exp_moves = 4;
`else
    exp_moves = 1;
`endif
    for (int i = 0; i < exp_moves; i++) exp_q.push_back(1 + W * (2 + i));
    repeat (40) @(posedge clock);
    @(negedge clock);
    player_direction = 4'b0000;
    repeat (10) @(posedge clock);
    #1;
    checks = checks + 1;
    if (move_count !== 16'(exp_moves) || player_y !== 8'(1 + exp_moves)) begin
      errors = errors + 1;
      $display("FAIL hold: count %0d y %0d, expected %0d %0d",
               move_count, player_y, exp_moves, 1 + exp_moves);
    end
    checks = checks + 1;
    if (exp_q.size() !== 0) begin
      errors = errors + 1;
      $display("FAIL hold_reads: %0d expected reads missing", exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 1'b1;
    test_reset();
    test_basic_right();
    test_wall();
    test_edge();
    test_exit();
    test_reset_mid();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
